sha256_block_unpad: RTL and testbench

//  Inverse of the SHA-256 single-block padder: accepts one 512-bit padded block and validates it.

---
 rtl/sha256_block_unpad.sv | 160 ++++++++++++++++
 tb/tb_sha256_block_unpad.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_block_unpad.sv
// SHA-256 single-block unpadder: validates a 512-bit padded block and recovers the message.
// Optional zero-fill scan enabled by defining UNPAD_FILL_CHECK_EN.
`timescale 1ns/1ps
module sha256_block_unpad #(
    parameter int unsigned MSG_WIDTH = 448,
    parameter int unsigned SCAN_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [511:0]         blk_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [MSG_WIDTH-1:0] msg_out,
    output logic [6:0]           byte_len,
    output logic [2:0]           err
);
    localparam int unsigned BLK_W = 512;
    localparam int unsigned LEN_W = 64;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HDR  = 2'd1;
    localparam logic [1:0] DONE = 2'd3;
`ifdef UNPAD_FILL_CHECK_EN
    localparam logic [1:0] SCAN = 2'd2;
    localparam int unsigned NCHUNK = MSG_WIDTH / SCAN_W;
    localparam int unsigned CNT_W  = $clog2(NCHUNK);
`endif

    if (MSG_WIDTH != 448 || (MSG_WIDTH % SCAN_W) != 0) begin : g_bad_cfg
        $error("sha256_block_unpad: unsupported MSG_WIDTH/SCAN_W");
    end

    logic [1:0]           state_q, state_d;
    logic [BLK_W-1:0]     blk_q, blk_d;
    logic [2:0]           err_q, err_d;
    logic [MSG_WIDTH-1:0] msg_q, msg_d;
    logic [6:0]           len_q, len_d;
    logic                 vld_q, vld_d;

    logic [LEN_W-1:0] len_f;
    logic             len_err;
    logic [8:0]       delim_idx;

    assign len_f     = blk_q[LEN_W-1:0];
    assign len_err   = (|len_f[63:9]) | (|len_f[2:0]) | (len_f[8:0] > 9'd440);
    assign delim_idx = 9'd511 - len_f[8:0];

`ifdef UNPAD_FILL_CHECK_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fill_hit;
    logic [9:0]       scan_idx;
    logic [9:0]       scan_lim;

    // Any set bit of the current chunk that lies below the delimiter position is a fill error.
    always_comb begin
        fill_hit = 1'b0;
        scan_idx = '0;
        scan_lim = 10'd511 - 10'(len_f[8:0]);
        for (int j = 0; j < int'(SCAN_W); j++) begin
            scan_idx = 10'(LEN_W + SCAN_W * int'(cnt_q) + j);
            if (blk_q[scan_idx[8:0]] && (scan_idx < scan_lim)) fill_hit = 1'b1;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        err_d   = err_q;
        msg_d   = msg_q;
        len_d   = len_q;
        vld_d   = vld_q;
`ifdef UNPAD_FILL_CHECK_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    blk_d   = blk_in;
                    err_d   = 3'b000;
                    state_d = HDR;
                end
            end
            HDR: begin
                if (len_err) begin
                    err_d[0] = 1'b1;
                    state_d  = DONE;
                end else begin
                    err_d[1] = ~blk_q[delim_idx];
`ifdef UNPAD_FILL_CHECK_EN
                    cnt_d    = '0;
                    state_d  = SCAN;
`else
                    state_d  = DONE;
`endif
                end
            end
`ifdef UNPAD_FILL_CHECK_EN
            SCAN: begin
                err_d[2] = err_q[2] | fill_hit;
                if (cnt_q == CNT_W'(NCHUNK - 1)) state_d = DONE;
                else                             cnt_d   = cnt_q + CNT_W'(1);
            end
`endif
            DONE: begin
                if (out_ready) begin
                    vld_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Result is formed once, on entry to DONE, and then held.
        if (state_d == DONE && state_q != DONE) begin
            vld_d = 1'b1;
            if (err_d == 3'b000) begin
                msg_d = blk_q[BLK_W-1:LEN_W] >> (9'd448 - len_f[8:0]);
                len_d = 7'(len_f[8:3]);
            end else begin
                msg_d = '0;
                len_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            blk_q   <= '0;
            err_q   <= '0;
            msg_q   <= '0;
            len_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            err_q   <= err_d;
            msg_q   <= msg_d;
            len_q   <= len_d;
            vld_q   <= vld_d;
        end
    end

`ifdef UNPAD_FILL_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`endif

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = vld_q;
    assign msg_out   = msg_q;
    assign byte_len  = len_q;
    assign err       = err_q;

endmodule

// File: tb/tb_sha256_block_unpad.sv
// Directed bench for sha256_block_unpad; expectations adapt to UNPAD_FILL_CHECK_EN.
`timescale 1ns/1ps
module tb_sha256_block_unpad;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [511:0] blk_in = '0;
    logic         in_ready;
    logic         out_valid;
    logic [447:0] msg_out;
    logic [6:0]   byte_len;
    logic [2:0]   err;

    int total = 0;
    int bad   = 0;

`ifdef UNPAD_FILL_CHECK_EN
    localparam int EXP_LAT = 16;
    localparam bit FILL    = 1'b1;
`else
    localparam int EXP_LAT = 2;
    localparam bit FILL    = 1'b0;
`endif

    localparam logic [511:0] ABC     = {32'h61626380, 416'h0, 64'd24};
    localparam logic [457:0] ABC_RES = {3'b000, 7'd3, 448'h616263};

    sha256_block_unpad dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .blk_in    (blk_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .msg_out   (msg_out),
        .byte_len  (byte_len),
        .err       (err)
    );

    always #5 clk = ~clk;

    logic [457:0] got;
    assign got = {err, byte_len, msg_out};

    // Present one block and return in cycle 1 (handshake edge has passed).
    task automatic send(input logic [511:0] b);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        blk_in   = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({out_valid, in_ready, got} !== {2'b00, 458'h0}) begin
            bad++; $display("FAIL reset_state: got %h want 0", {out_valid, in_ready, got});
        end
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_abc();
        int lat;
        send(ABC);
        wait_out(lat);
        total++;
        if (lat !== EXP_LAT) begin
            bad++; $display("FAIL abc_latency: got %0d want %0d", lat, EXP_LAT);
        end
        total++;
        if (got !== ABC_RES) begin
            bad++; $display("FAIL abc_result: got %h want %h", got, ABC_RES);
        end
        consume();
    endtask

    task automatic test_len_err();
        int lat;
        logic [457:0] exp_r = {3'b001, 7'd0, 448'h0};
        send({32'h61626380, 416'h0, 64'd25});
        wait_out(lat);
        total++;
        if (got !== exp_r || lat !== 2) begin
            bad++; $display("FAIL len_unaligned: got %h lat %0d want %h lat 2", got, lat, exp_r);
        end
        consume();
        send({32'h61626380, 416'h0, 64'h1_0000_0018});
        wait_out(lat);
        total++;
        if (got !== exp_r) begin
            bad++; $display("FAIL len_high_bits: got %h want %h", got, exp_r);
        end
        consume();
        send({{448{1'b1}}, 64'd448});
        wait_out(lat);
        total++;
        if (got !== exp_r) begin
            bad++; $display("FAIL len_448: got %h want %h", got, exp_r);
        end
        consume();
    endtask

    task automatic test_delim_err();
        int lat;
        logic [457:0] exp_r = {3'b010, 7'd0, 448'h0};
        send({32'h61626300, 416'h0, 64'd24});
        wait_out(lat);
        total++;
        if (got !== exp_r) begin
            bad++; $display("FAIL delim_missing: got %h want %h", got, exp_r);
        end
        consume();
    endtask

    task automatic test_fill();
        int lat;
        logic [511:0] b = ABC;
        logic [457:0] exp_r = FILL ? {3'b100, 7'd0, 448'h0} : ABC_RES;
        b[100] = 1'b1;
        send(b);
        wait_out(lat);
        total++;
        if (got !== exp_r) begin
            bad++; $display("FAIL fill_stray_bit: got %h want %h", got, exp_r);
        end
        consume();
    endtask

    task automatic test_l0();
        int lat;
        send({1'b1, 447'h0, 64'd0});
        wait_out(lat);
        total++;
        if (got !== 458'h0 || lat !== EXP_LAT) begin
            bad++; $display("FAIL len_zero: got %h lat %0d want 0 lat %0d", got, lat, EXP_LAT);
        end
        consume();
    endtask

    // Max-length block held under backpressure, with the next block waiting upstream.
    task automatic test_back_to_back();
        int lat;
        logic [457:0] exp_r = {3'b000, 7'd55, 8'h00, {440{1'b1}}};
        send({{440{1'b1}}, 8'h80, 64'd440});
        wait_out(lat);
        total++;
        if (got !== exp_r) begin
            bad++; $display("FAIL len_440: got %h want %h", got, exp_r);
        end
        blk_in   = ABC;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++;
            if ({out_valid, in_ready, got} !== {2'b10, exp_r}) begin
                bad++; $display("FAIL hold_cycle%0d: got v=%b r=%b %h want v=1 r=0 %h",
                                i, out_valid, in_ready, got, exp_r);
            end
        end
        consume();
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++; $display("FAIL after_consume: got v=%b r=%b want v=0 r=1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(lat);
        total++;
        if (got !== ABC_RES || lat !== EXP_LAT) begin
            bad++; $display("FAIL queued_block: got %h lat %0d want %h lat %0d",
                            got, lat, ABC_RES, EXP_LAT);
        end
        consume();
    endtask

    task automatic test_reset_mid();
        int  lat;
        bit  seen = 1'b0;
        send(ABC);
        for (int i = 0; i < EXP_LAT - 10; i++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL ready_in_reset: got %b want 0", in_ready);
        end
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL valid_after_reset: got %b want 0", out_valid);
        end
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL ready_after_release: got %b want 1", in_ready);
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++; $display("FAIL discarded_result: got out_valid=1 want 0");
        end
        send(ABC);
        wait_out(lat);
        total++;
        if (got !== ABC_RES || lat !== EXP_LAT) begin
            bad++; $display("FAIL post_reset_abc: got %h lat %0d want %h lat %0d",
                            got, lat, ABC_RES, EXP_LAT);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_abc();
        test_len_err();
        test_delim_err();
        test_fill();
        test_l0();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
